// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: CHANNELS independent programmable tick generators, periodic or one-shot, period T+1.
// Optional per-channel square-wave divider outputs exist only when PGEN_DIV_OUT_EN is defined.
module pulse_gen_multi #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 17,
    parameter int DEFAULT_TC = 99_999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] oneshot,
    input  logic [CHANNELS-1:0] start,
    input  logic                load,
    input  logic [3:0]          load_ch,
    input  logic [WIDTH-1:0]    load_tc,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] div_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [WIDTH-1:0]    cnt_d   [CHANNELS];
    logic [WIDTH-1:0]    tc_q    [CHANNELS];
    logic [WIDTH-1:0]    tc_d    [CHANNELS];
    // Mode captured at RUN entry so a mid-run oneshot change waits for the next start.
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] mode_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i]  = (state_q[i] == RUN);
            pulse[i] = (state_q[i] == RUN) && (cnt_q[i] == tc_q[i]);
        end
    end

    always_comb begin
        mode_d = mode_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            tc_d[i]    = tc_q[i];
            case (state_q[i])
                IDLE: begin
                    if (enable[i] && (!oneshot[i] || start[i])) begin
                        state_d[i] = RUN;
                        mode_d[i]  = oneshot[i];
                    end
                end
                RUN: begin
                    if (!enable[i] || (mode_q[i] && pulse[i])) begin
                        state_d[i] = IDLE;
                    end else if (!pulse[i]) begin
                        cnt_d[i] = cnt_q[i] + WIDTH'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            // Out-of-range load_ch matches no channel and is dropped.
            if (load && (load_ch == 4'(i))) begin
                tc_d[i]  = load_tc;
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                tc_q[i]    <= WIDTH'(DEFAULT_TC);
            end
            mode_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                tc_q[i]    <= tc_d[i];
            end
            mode_q <= mode_d;
        end
    end

`ifdef PGEN_DIV_OUT_EN
    logic [CHANNELS-1:0] div_q;
    logic [CHANNELS-1:0] div_d;

    always_comb begin
        div_d = div_q ^ pulse;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign div_out = div_q;
`else
    assign div_out = '0;
`endif

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: expected pulse/busy/div_out per cycle are queued, then popped and checked.
// DEFAULT_TC is shortened to 9 so the default-period case fits a short run.
module tb_pulse_gen_multi;

    localparam int CH = 4;
    localparam int W  = 17;
    localparam int DT = 9;
`ifdef PGEN_DIV_OUT_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] enable;
    logic [CH-1:0] oneshot;
    logic [CH-1:0] start;
    logic          load;
    logic [3:0]    load_ch;
    logic [W-1:0]  load_tc;
    logic [CH-1:0] pulse;
    logic [CH-1:0] busy;
    logic [CH-1:0] div_out;

    typedef struct {
        string      tag;
        logic [3:0] p;
        logic [3:0] b;
        logic [3:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pulse_gen_multi #(
        .CHANNELS  (CH),
        .WIDTH     (W),
        .DEFAULT_TC(DT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .oneshot(oneshot),
        .start  (start),
        .load   (load),
        .load_ch(load_ch),
        .load_tc(load_tc),
        .pulse  (pulse),
        .busy   (busy),
        .div_out(div_out)
    );

    task automatic push(input string tag, input logic [3:0] p, input logic [3:0] b, input logic [3:0] d);
        exp_t e;
        e.tag = tag;
        e.p   = p;
        e.b   = b;
        e.d   = DIV_EN ? d : 4'b0000;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        exp_t e;
        n_assert++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: got size %0d, expected >0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (pulse === e.p) else begin
                n_fail++;
                $error("FAIL %s pulse: got %b expected %b", e.tag, pulse, e.p);
            end
            n_assert++;
            assert (busy === e.b) else begin
                n_fail++;
                $error("FAIL %s busy: got %b expected %b", e.tag, busy, e.b);
            end
            n_assert++;
            assert (div_out === e.d) else begin
                n_fail++;
                $error("FAIL %s div_out: got %b expected %b", e.tag, div_out, e.d);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        enable  = '0;
        oneshot = '0;
        start   = '0;
        load    = 1'b0;
        load_ch = 4'd0;
        load_tc = '0;

        // Reset state
        #1;
        push("reset_async", 4'b0000, 4'b0000, 4'b0000);
        pop_check();
        tick();
        tick();
        push("in_reset", 4'b0000, 4'b0000, 4'b0000);
        pop_check();
        reset = 1'b0;
        tick();
        push("after_reset", 4'b0000, 4'b0000, 4'b0000);
        pop_check();

        // ch0 periodic with the reset terminal count
        enable[0] = 1'b1;
        for (int j = 0; j < 25; j++)
            push("periodic_default", (j % 10 == 9) ? 4'b0001 : 4'b0000, 4'b0001,
                 ((j / 10) % 2 == 1) ? 4'b0001 : 4'b0000);
        for (int j = 0; j < 25; j++) begin
            tick();
            pop_check();
        end
        enable[0] = 1'b0;
        push("ch0_stop", 4'b0000, 4'b0000, 4'b0000);
        tick();
        pop_check();

        // ch1 periodic T=3
        load = 1'b1; load_ch = 4'd1; load_tc = 17'd3;
        push("load_ch1_idle", 4'b0000, 4'b0000, 4'b0000);
        tick();
        pop_check();
        load = 1'b0;
        enable[1] = 1'b1;
        for (int j = 0; j < 12; j++)
            push("periodic_t3", (j % 4 == 3) ? 4'b0010 : 4'b0000, 4'b0010,
                 ((j / 4) % 2 == 1) ? 4'b0010 : 4'b0000);
        for (int j = 0; j < 12; j++) begin
            tick();
            pop_check();
        end

        // Reload ch1 with T=1 while cnt==tc, then an out-of-range load
        load = 1'b1; load_ch = 4'd1; load_tc = 17'd1;
        for (int j = 12; j < 19; j++)
            push("reload_t1", (j >= 13 && j % 2 == 1) ? 4'b0010 : 4'b0000, 4'b0010,
                 (((j - 12) / 2) % 2 == 0) ? 4'b0010 : 4'b0000);
        tick();
        pop_check();
        load_ch = 4'd9; load_tc = 17'd0;
        for (int j = 13; j < 19; j++) begin
            tick();
            pop_check();
        end
        load = 1'b0;
        enable[1] = 1'b0;
        push("ch1_stop", 4'b0000, 4'b0000, 4'b0000);
        tick();
        pop_check();

        // ch2 one-shot T=5 with an ignored retrigger
        load = 1'b1; load_ch = 4'd2; load_tc = 17'd5;
        push("load_ch2", 4'b0000, 4'b0000, 4'b0000);
        tick();
        pop_check();
        load = 1'b0;
        oneshot[2] = 1'b1; enable[2] = 1'b1; start[2] = 1'b1;
        for (int j = 0; j < 9; j++)
            push("oneshot_t5", (j == 5) ? 4'b0100 : 4'b0000, (j <= 5) ? 4'b0100 : 4'b0000,
                 (j >= 6) ? 4'b0100 : 4'b0000);
        for (int j = 0; j < 9; j++) begin
            tick();
            pop_check();
            if (j == 0) start[2] = 1'b0;
            if (j == 2) start[2] = 1'b1;
            if (j == 3) start[2] = 1'b0;
        end

        // ch3 one-shot T=5 aborted by reset at cnt=2
        load = 1'b1; load_ch = 4'd3; load_tc = 17'd5;
        push("load_ch3", 4'b0000, 4'b0000, 4'b0100);
        tick();
        pop_check();
        load = 1'b0;
        oneshot[3] = 1'b1; enable[3] = 1'b1; start[3] = 1'b1;
        for (int j = 0; j < 3; j++)
            push("oneshot_pre_reset", 4'b0000, 4'b1000, 4'b0100);
        for (int j = 0; j < 3; j++) begin
            tick();
            pop_check();
            if (j == 0) start[3] = 1'b0;
        end
        reset = 1'b1;
        #1;
        push("reset_midcount", 4'b0000, 4'b0000, 4'b0000);
        pop_check();
        tick();
        reset = 1'b0;
        for (int j = 0; j < 12; j++)
            push("post_reset_idle", 4'b0000, 4'b0000, 4'b0000);
        for (int j = 0; j < 12; j++) begin
            tick();
            pop_check();
        end

        // ch3 periodic again: period shows tc restored to the reset value
        oneshot[3] = 1'b0;
        for (int j = 0; j < 13; j++)
            push("tc_restored", (j == 9) ? 4'b1000 : 4'b0000, 4'b1000,
                 (j >= 10) ? 4'b1000 : 4'b0000);
        for (int j = 0; j < 13; j++) begin
            tick();
            pop_check();
        end
        enable[3] = 1'b0;
        push("ch3_stop", 4'b0000, 4'b0000, 4'b1000);
        tick();
        pop_check();

        // ch0 periodic T=0: pulse every RUN cycle
        load = 1'b1; load_ch = 4'd0; load_tc = 17'd0;
        push("load_ch0_t0", 4'b0000, 4'b0000, 4'b1000);
        tick();
        pop_check();
        load = 1'b0;
        enable[0] = 1'b1;
        for (int j = 0; j < 6; j++)
            push("periodic_t0", 4'b0001, 4'b0001, (j % 2 == 1) ? 4'b1001 : 4'b1000);
        for (int j = 0; j < 6; j++) begin
            tick();
            pop_check();
        end
        enable[0] = 1'b0;
        push("ch0_t0_stop", 4'b0000, 4'b0000, 4'b1000);
        tick();
        pop_check();

        // ch1 one-shot T=0: pulse in first RUN cycle only
        load = 1'b1; load_ch = 4'd1; load_tc = 17'd0;
        push("load_ch1_t0", 4'b0000, 4'b0000, 4'b1000);
        tick();
        pop_check();
        load = 1'b0;
        oneshot[1] = 1'b1; enable[1] = 1'b1; start[1] = 1'b1;
        push("oneshot_t0_run", 4'b0010, 4'b0010, 4'b1000);
        push("oneshot_t0_done", 4'b0000, 4'b0000, 4'b1010);
        push("oneshot_t0_idle", 4'b0000, 4'b0000, 4'b1010);
        tick();
        pop_check();
        start[1] = 1'b0;
        tick();
        pop_check();
        tick();
        pop_check();

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_gen_multi.md
PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent pulse channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 17, counter and period width in bits.
REQ-003 SHALL have parameter DEFAULT_TC, default 99_999, reset terminal count of every channel (1 ms at 100 MHz).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  input  CHANNELS  per-channel run enable.
REQ-007 SHALL have port oneshot  input  CHANNELS  per-channel mode: 0 periodic, 1 one-shot.
REQ-008 SHALL have port start  input  CHANNELS  per-channel one-shot trigger, sampled on the clock edge.
REQ-009 SHALL have port load  input  1  terminal-count write strobe.
REQ-010 SHALL have port load_ch  input  4  channel index for load.
REQ-011 SHALL have port load_tc  input  WIDTH  new terminal count T; period = T+1 cycles.
REQ-012 SHALL have port pulse  output  CHANNELS  one-cycle tick per channel.
REQ-013 SHALL have port busy  output  CHANNELS  channel in RUN state.
REQ-014 SHALL have port div_out  output  CHANNELS  square-wave output per channel (see Configuration).

Function
REQ-015 Each channel SHALL hold a WIDTH-bit terminal count tc[i], a WIDTH-bit counter cnt[i] and a two-state FSM {IDLE, RUN}.
REQ-016 pulse[i] SHALL be a combinational decode: 1 exactly when state RUN and cnt[i]==tc[i]; busy[i] SHALL equal (state==RUN).
REQ-017 In RUN, cnt[i] SHALL increment by 1 each cycle and SHALL wrap to 0 on the cycle after cnt[i]==tc[i]; cnt[i] SHALL never exceed tc[i].
REQ-018 In IDLE, cnt[i] SHALL be held at 0.
REQ-019 Periodic mode: IDLE->RUN on an edge with enable[i]=1; RUN->IDLE on an edge with enable[i]=0. First pulse SHALL occur T cycles after the first RUN cycle; pulses then repeat every T+1 cycles.
REQ-020 One-shot mode: IDLE->RUN on an edge with enable[i]=1 and start[i]=1; RUN->IDLE on the edge following the pulse cycle; exactly one pulse per trigger.
REQ-021 start[i] while already in RUN SHALL be ignored (no retrigger, no counter restart).
REQ-022 enable[i]=0 SHALL force IDLE on the next edge from any state, aborting a one-shot without a pulse.
REQ-023 Changing oneshot[i] SHALL take effect only at the next IDLE->RUN transition.
REQ-024 load=1 with load_ch<CHANNELS SHALL write tc[load_ch]<=load_tc and clear cnt[load_ch] to 0 on the same edge; the FSM state SHALL be unchanged.
REQ-025 load with load_ch>=CHANNELS SHALL be ignored.
REQ-026 Load coinciding with cnt==tc SHALL still show pulse in that cycle; counting resumes from 0 with the new T.
REQ-027 T=0 SHALL give pulse high every RUN cycle (periodic) or a pulse in the first RUN cycle (one-shot).
REQ-028 Channels SHALL be fully independent; no shared counter.

Reset
REQ-029 Reset SHALL set every tc[i] to DEFAULT_TC, every cnt[i] to 0, every FSM to IDLE, and div_out to 0.
REQ-030 Outputs during and right after reset SHALL be pulse=0 and busy=0; reset mid-count SHALL abort without a pulse.

Configuration
REQ-031 Macro PGEN_DIV_OUT_EN defined: div_out[i] SHALL toggle on every edge where pulse[i]=1, giving a square wave of period 2(T+1) in periodic mode.
REQ-032 Macro PGEN_DIV_OUT_EN undefined: div_out SHALL be constant 0 and no toggle registers SHALL be synthesised.

Verification
REQ-033 Reset, enable[0]=1 periodic with default T -> first pulse[0] at count 99_999, repeating every 100_000 cycles; pulse[1..3] stay 0.
REQ-034 load ch1 T=3, enable[1]=1 periodic -> pulse[1] high in RUN cycles 4, 8, 12; busy[1]=1 throughout.
REQ-035 ch2 T=5, oneshot=1, start pulse -> single pulse[2] 5 cycles after RUN entry, busy[2] falls next edge; second start during RUN ignored.
REQ-036 ch1 running T=3, at cnt=3 load T=1 -> pulse that cycle, then pulses every 2 cycles; load_ch=9 changes nothing.
REQ-037 Reset asserted at cnt=2 of a one-shot with T=5 -> no pulse, busy=0, tc back to 99_999.
REQ-038 PGEN_DIV_OUT_EN defined, T=3 periodic -> div_out toggles every 4 cycles (period 8); undefined -> div_out constant 0.
